grid_cell_painter: RTL and testbench

//  Pixel-colour stage directly downstream of hvsync_generator. Divides the visible area into a
//  3x3 grid of cells, each holding a 3-bit {R,G,B} colour. Debounced buttons move a cursor and

---
 rtl/grid_cell_painter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_grid_cell_painter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/grid_cell_painter.sv
// 3x3 grid colour painter downstream of hvsync_generator: debounced cursor/commit buttons,
// 2-clock pixel pipeline with matched syncs. Optional blinking cursor via `CURSOR_BLINK_EN.
module grid_cell_painter #(
    parameter int unsigned GRID_X0      = 20,
    parameter int unsigned GRID_Y0      = 0,
    parameter int unsigned CELL_W       = 200,
    parameter int unsigned CELL_H       = 160,
    parameter int unsigned BORDER       = 4,
    parameter int unsigned DEBOUNCE_CYC = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] counter_x,
    input  logic [9:0] counter_y,
    input  logic       in_display_area,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       sw_cp,
    input  logic       sw_cc,
    input  logic       sw_r,
    input  logic       sw_g,
    input  logic       sw_b,
    output logic [2:0] pixel,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [3:0] cursor_pos
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

    localparam logic [9:0] XB0    = 10'(GRID_X0);
    localparam logic [9:0] YB0    = 10'(GRID_Y0);
    localparam logic [9:0] CellW  = 10'(CELL_W);
    localparam logic [9:0] CellW2 = 10'(2 * CELL_W);
    localparam logic [9:0] SpanX  = 10'(3 * CELL_W);
    localparam logic [9:0] CellH  = 10'(CELL_H);
    localparam logic [9:0] CellH2 = 10'(2 * CELL_H);
    localparam logic [9:0] SpanY  = 10'(3 * CELL_H);
    localparam logic [9:0] BordLo = 10'(BORDER);
    localparam logic [9:0] BordHx = 10'(CELL_W - BORDER);
    localparam logic [9:0] BordHy = 10'(CELL_H - BORDER);

    typedef enum logic [1:0] {StIdle, StWaitBlank, StWrite} state_e;

    // ---------------- Input synchronisers: {cp, cc, r, g, b} ----------------
    logic [4:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= {sw_cp, sw_cc, sw_r, sw_g, sw_b};
            sync2_q <= sync1_q;
        end
    end

    // ---------------- Debounce: [1]=cp, [0]=cc ----------------
    logic [1:0]      btn_low;
    logic [CntW-1:0] db_cnt_q [2];
    logic [CntW-1:0] db_cnt_d [2];
    logic [1:0]      armed_q, armed_d;
    logic [1:0]      press_evt;

    assign btn_low = ~sync2_q[4:3];

    // Armed: count stable-low samples to a press. Disarmed: count stable-high samples to re-arm.
    always_comb begin
        armed_d   = armed_q;
        press_evt = '0;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            if (armed_q[i]) begin
                if (!btn_low[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] == CntLast) begin
                    db_cnt_d[i]  = '0;
                    press_evt[i] = 1'b1;
                    armed_d[i]   = 1'b0;
                end
            end else begin
                if (btn_low[i]) begin
                    db_cnt_d[i] = '0;
                end else if (db_cnt_q[i] == CntLast) begin
                    db_cnt_d[i] = '0;
                    armed_d[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= '1;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            armed_q <= armed_d;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    logic cp_evt, cc_evt;
    assign cp_evt = press_evt[1];
    assign cc_evt = press_evt[0];

    // ---------------- Cursor ----------------
    logic [3:0] cursor_q, cursor_d;

    always_comb begin
        cursor_d = cursor_q;
        if (cp_evt) cursor_d = (cursor_q == 4'd8) ? 4'd0 : cursor_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cursor_q <= '0;
        else        cursor_q <= cursor_d;
    end

    assign cursor_pos = cursor_q;

    // ---------------- Commit FSM ----------------
    state_e     state_q, state_d;
    logic [3:0] pend_cell_q, pend_cell_d;
    logic [2:0] pend_rgb_q, pend_rgb_d;
    logic       vsync_prev_q;
    logic       vsync_fall;
    logic       cell_we;
    logic [2:0] cell_q [9];

    assign vsync_fall = vsync_prev_q & ~vsync_in;

    always_comb begin
        state_d     = state_q;
        pend_cell_d = pend_cell_q;
        pend_rgb_d  = pend_rgb_q;
        cell_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cc_evt) begin
                    pend_cell_d = cursor_q;
                    pend_rgb_d  = ~sync2_q[2:0];
                    state_d     = StWaitBlank;
                end
            end
            StWaitBlank: begin
                if (cc_evt) begin
                    pend_cell_d = cursor_q;
                    pend_rgb_d  = ~sync2_q[2:0];
                end
                if (vsync_fall) state_d = StWrite;
            end
            StWrite: begin
                cell_we = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pend_cell_q  <= '0;
            pend_rgb_q   <= '0;
            vsync_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            pend_cell_q  <= pend_cell_d;
            pend_rgb_q   <= pend_rgb_d;
            vsync_prev_q <= vsync_in;
        end
    end

    // Reset pattern (i%7)+1 keeps every cell non-black.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 9; i++) cell_q[i] <= 3'((i % 7) + 1);
        end else if (cell_we && (pend_cell_q < 4'd9)) begin
            cell_q[pend_cell_q] <= pend_rgb_q;
        end
    end

    // ---------------- Cursor blink ----------------
    logic show_border;
`ifdef CURSOR_BLINK_EN
    logic [4:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          frame_cnt_q <= '0;
        else if (vsync_fall) frame_cnt_q <= frame_cnt_q + 5'd1;
    end

    assign show_border = frame_cnt_q[4];
`else
    assign show_border = 1'b1;
`endif

    // ---------------- Pixel pipeline stage 1 ----------------
    logic [9:0] x_rel, y_rel, x_cell, y_cell;
    logic [1:0] col_s1, row_s1;
    logic       in_grid_s1, border_s1;

    // Offsets relative to the grid origin; coordinates left of/above it wrap high and fail the span test.
    always_comb begin
        x_rel  = counter_x - XB0;
        y_rel  = counter_y - YB0;
        col_s1 = 2'd2;
        x_cell = x_rel - CellW2;
        if (x_rel < CellW) begin
            col_s1 = 2'd0;
            x_cell = x_rel;
        end else if (x_rel < CellW2) begin
            col_s1 = 2'd1;
            x_cell = x_rel - CellW;
        end
        row_s1 = 2'd2;
        y_cell = y_rel - CellH2;
        if (y_rel < CellH) begin
            row_s1 = 2'd0;
            y_cell = y_rel;
        end else if (y_rel < CellH2) begin
            row_s1 = 2'd1;
            y_cell = y_rel - CellH;
        end
        in_grid_s1 = (x_rel < SpanX) && (y_rel < SpanY);
        border_s1  = (x_cell < BordLo) || (x_cell >= BordHx) ||
                     (y_cell < BordLo) || (y_cell >= BordHy);
    end

    logic [1:0] col_q, row_q;
    logic       in_grid_q, disp_q, border_q;
    logic       hsync_s1_q, vsync_s1_q, hsync_s2_q, vsync_s2_q;
    logic [2:0] pixel_q, pixel_d;

    // ---------------- Pixel pipeline stage 2 ----------------
    logic [3:0] idx;
    logic [2:0] cell_col;

    always_comb begin
        idx      = {2'b00, col_q} + {1'b0, row_q, 1'b0} + {2'b00, row_q};
        cell_col = (idx < 4'd9) ? cell_q[idx] : 3'b000;
        pixel_d  = cell_col;
        if (!disp_q || !in_grid_q) begin
            pixel_d = 3'b000;
        end else if ((idx == cursor_q) && border_q && show_border) begin
            pixel_d = ~cell_col;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            in_grid_q  <= 1'b0;
            disp_q     <= 1'b0;
            border_q   <= 1'b0;
            hsync_s1_q <= 1'b1;
            vsync_s1_q <= 1'b1;
            hsync_s2_q <= 1'b1;
            vsync_s2_q <= 1'b1;
            pixel_q    <= '0;
        end else begin
            col_q      <= col_s1;
            row_q      <= row_s1;
            in_grid_q  <= in_grid_s1;
            disp_q     <= in_display_area;
            border_q   <= border_s1;
            hsync_s1_q <= hsync_in;
            vsync_s1_q <= vsync_in;
            hsync_s2_q <= hsync_s1_q;
            vsync_s2_q <= vsync_s1_q;
            pixel_q    <= pixel_d;
        end
    end

    assign pixel     = pixel_q;
    assign hsync_out = hsync_s2_q;
    assign vsync_out = vsync_s2_q;

endmodule

// File: tb/tb_grid_cell_painter.sv
// Directed self-checking bench for grid_cell_painter with DEBOUNCE_CYC=8.
module tb_grid_cell_painter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] counter_x, counter_y;
    logic       in_display_area, hsync_in, vsync_in;
    logic       sw_cp, sw_cc, sw_r, sw_g, sw_b;
    logic [2:0] pixel;
    logic       hsync_out, vsync_out;
    logic [3:0] cursor_pos;

    int n_checks = 0;
    int n_errors = 0;

    grid_cell_painter #(
        .DEBOUNCE_CYC(8)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .counter_x       (counter_x),
        .counter_y       (counter_y),
        .in_display_area (in_display_area),
        .hsync_in        (hsync_in),
        .vsync_in        (vsync_in),
        .sw_cp           (sw_cp),
        .sw_cc           (sw_cc),
        .sw_r            (sw_r),
        .sw_g            (sw_g),
        .sw_b            (sw_b),
        .pixel           (pixel),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out),
        .cursor_pos      (cursor_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a coordinate, wait out the 2-clock pipeline, compare pixel.
    task automatic px(input int x, input int y, input logic d, input logic [2:0] exp,
                      input string tag);
        @(negedge clk);
        counter_x       = 10'(x);
        counter_y       = 10'(y);
        in_display_area = d;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check(tag, {29'd0, pixel}, {29'd0, exp});
    endtask

    task automatic press(input bit cp, input bit cc);
        @(negedge clk);
        if (cp) sw_cp = 1'b0;
        if (cc) sw_cc = 1'b0;
        repeat (20) @(negedge clk);
        sw_cp = 1'b1;
        sw_cc = 1'b1;
        repeat (14) @(negedge clk);
    endtask

    task automatic vblank();
        @(negedge clk);
        vsync_in = 1'b0;
        @(negedge clk);
        check("vsync_out_lag1", {31'd0, vsync_out}, 32'd1);
        @(negedge clk);
        check("vsync_out_lag2", {31'd0, vsync_out}, 32'd0);
        repeat (3) @(negedge clk);
        vsync_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        counter_x = '0; counter_y = '0; in_display_area = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        sw_cp = 1'b1; sw_cc = 1'b1; sw_r = 1'b1; sw_g = 1'b1; sw_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pixel", {29'd0, pixel}, 32'd0);
        check("rst_hsync", {31'd0, hsync_out}, 32'd1);
        check("rst_vsync", {31'd0, vsync_out}, 32'd1);
        check("rst_cursor", {28'd0, cursor_pos}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1. Colour lookup
        px(120, 80, 1'b1, 3'b001, "cell0_colour");
        px(520, 400, 1'b1, 3'b010, "cell8_colour");
        @(negedge clk);
        hsync_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("hsync_delay", {31'd0, hsync_out}, 32'd0);
        hsync_in = 1'b1;

        // 2. Bounce then clean press, then wrap through nine presses
        @(negedge clk);
        sw_cp = 1'b0;
        repeat (5) @(negedge clk);
        sw_cp = 1'b1;
        repeat (3) @(negedge clk);
        check("bounce_no_step", {28'd0, cursor_pos}, 32'd0);
        press(1'b1, 1'b0);
        check("one_step", {28'd0, cursor_pos}, 32'd1);
        for (int i = 0; i < 9; i++) press(1'b1, 1'b0);
        check("wrap_nine", {28'd0, cursor_pos}, 32'd1);

        // 3. Commit red into cell 4, lands only on vsync fall
        for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
        check("cursor_at4", {28'd0, cursor_pos}, 32'd4);
        sw_r = 1'b0;
        press(1'b0, 1'b1);
        px(320, 240, 1'b1, 3'b101, "cell4_before_blank");
        vblank();
        px(320, 240, 1'b1, 3'b100, "cell4_after_blank");
        px(220, 240, 1'b1, 3'b011, "cell4_border_inv");
        sw_r = 1'b1;

        // 4. Simultaneous cp and cc at cursor 3
        for (int i = 0; i < 8; i++) press(1'b1, 1'b0);
        check("cursor_at3", {28'd0, cursor_pos}, 32'd3);
        sw_g = 1'b0;
        press(1'b1, 1'b1);
        sw_g = 1'b1;
        check("cursor_after_both", {28'd0, cursor_pos}, 32'd4);
        vblank();
        px(120, 240, 1'b1, 3'b010, "cell3_written");

        // 5. Reset discards a pending commit and restores the pattern
        sw_r = 1'b0; sw_g = 1'b0; sw_b = 1'b0;
        press(1'b0, 1'b1);
        sw_r = 1'b1; sw_g = 1'b1; sw_b = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_pixel", {29'd0, pixel}, 32'd0);
        check("midrst_cursor", {28'd0, cursor_pos}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        vblank();
        px(320, 240, 1'b1, 3'b101, "cell4_restored");
        px(120, 240, 1'b1, 3'b100, "cell3_restored");

        // 6. Boundaries on y=80 with cursor 0
        px(19, 80, 1'b1, 3'b000, "x19_outside");
`ifdef CURSOR_BLINK_EN
        px(20, 80, 1'b1, 3'b001, "x20_border_hidden");
`else
        px(20, 80, 1'b1, 3'b110, "x20_border");
`endif
        px(30, 80, 1'b1, 3'b001, "x30_interior");
        px(619, 80, 1'b1, 3'b011, "x619_cell2");
        px(620, 80, 1'b1, 3'b000, "x620_outside");
        px(120, 80, 1'b0, 3'b000, "disp_off");
        px(320, 480, 1'b1, 3'b000, "y480_outside");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
